// File: rtl/combination_block.sv
// -----------------------------------------------------------------------------
// combination_block
//   GCN combination stage: aggregates FM_WM rows over a COO edge list into
//   per-node accumulators (self loop plus both directions of every edge),
//   then writes the per-node argmax class into y.
//
//   Optional build macro:
//     COMB_SATURATE_EN  defined   -> accumulator elements saturate at all-ones
//                       undefined -> accumulator elements wrap (default)
//
//   Ports:
//     clk, reset      clock, asynchronous active-high reset
//     start           one-cycle launch (from transformation done)
//     fm_wm_row_in    FM_WM row selected by read_row (same-cycle data)
//     coo_in          edge at coo_address: [0]=source, [1]=destination
//     read_row        FM_WM row select
//     coo_address     edge index
//     enable_read     high while FM_WM / COO data is consumed
//     done_comb       one-cycle completion pulse
//     y               per-node argmax class, held until the next ARGMAX
// -----------------------------------------------------------------------------
module combination_block #(
    parameter int FEATURE_ROWS      = 6,
    parameter int WEIGHT_COLS       = 3,
    parameter int DOT_PROD_WIDTH    = 16,
    parameter int NUM_EDGES         = 6,
    parameter int COO_BW            = 3,
    parameter int MAX_ADDRESS_WIDTH = 2,
    localparam int RW = $clog2(FEATURE_ROWS),
    localparam int EW = $clog2(NUM_EDGES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DOT_PROD_WIDTH-1:0]    fm_wm_row_in [0:WEIGHT_COLS-1],
    input  logic [COO_BW-1:0]            coo_in [0:1],
    output logic [RW-1:0]                read_row,
    output logic [EW-1:0]                coo_address,
    output logic                         enable_read,
    output logic                         done_comb,
    output logic [MAX_ADDRESS_WIDTH-1:0] y [0:FEATURE_ROWS-1]
);

    typedef enum logic [2:0] {IDLE, INIT, EDGE_A, EDGE_B, ARGMAX, DONE} state_t;

    state_t state, state_nxt;

    logic [RW-1:0]             row_cnt;
    logic [EW-1:0]             edge_cnt;
    logic [DOT_PROD_WIDTH-1:0] adj [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1];

    logic [COO_BW-1:0] src, dst;
    logic              edge_ok;
    logic              row_last, edge_last;

    logic [DOT_PROD_WIDTH-1:0]    best_val;
    logic [MAX_ADDRESS_WIDTH-1:0] best_idx;

    assign src       = coo_in[0];
    assign dst       = coo_in[1];
    // An edge touching a non-existent node is skipped entirely.
    assign edge_ok   = (int'(src) < FEATURE_ROWS) && (int'(dst) < FEATURE_ROWS);
    assign row_last  = (row_cnt == RW'(FEATURE_ROWS - 1));
    assign edge_last = (edge_cnt == EW'(NUM_EDGES - 1));

    function automatic logic [DOT_PROD_WIDTH-1:0] acc_add(
        input logic [DOT_PROD_WIDTH-1:0] a,
        input logic [DOT_PROD_WIDTH-1:0] b
    );
        logic [DOT_PROD_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef COMB_SATURATE_EN
        return s[DOT_PROD_WIDTH] ? '1 : s[DOT_PROD_WIDTH-1:0];
`else
        return s[DOT_PROD_WIDTH-1:0];
`endif
    endfunction

    // Argmax of the accumulator row under row_cnt; strict '>' keeps the
    // lowest index on ties.
    always_comb begin
        best_val = adj[row_cnt][0];
        best_idx = '0;
        for (int c = 1; c < WEIGHT_COLS; c++) begin
            if (adj[row_cnt][c] > best_val) begin
                best_val = adj[row_cnt][c];
                best_idx = MAX_ADDRESS_WIDTH'(c);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        read_row    = '0;
        coo_address = '0;
        enable_read = 1'b0;
        done_comb   = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = INIT;
            INIT: begin
                enable_read = 1'b1;
                read_row    = row_cnt;
                if (row_last) state_nxt = EDGE_A;
            end
            EDGE_A: begin
                enable_read = 1'b1;
                coo_address = edge_cnt;
                read_row    = RW'(src);
                state_nxt   = EDGE_B;
            end
            EDGE_B: begin
                enable_read = 1'b1;
                coo_address = edge_cnt;
                read_row    = RW'(dst);
                state_nxt   = edge_last ? ARGMAX : EDGE_A;
            end
            ARGMAX: if (row_last) state_nxt = DONE;
            DONE: begin
                done_comb = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_cnt  <= '0;
            edge_cnt <= '0;
            for (int n = 0; n < FEATURE_ROWS; n++) begin
                y[n] <= '0;
                for (int c = 0; c < WEIGHT_COLS; c++) adj[n][c] <= '0;
            end
        end else begin
            case (state)
                INIT: begin
                    for (int c = 0; c < WEIGHT_COLS; c++) adj[row_cnt][c] <= fm_wm_row_in[c];
                    row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                end
                EDGE_A: begin
                    if (edge_ok)
                        for (int c = 0; c < WEIGHT_COLS; c++)
                            adj[dst][c] <= acc_add(adj[dst][c], fm_wm_row_in[c]);
                end
                EDGE_B: begin
                    // A self edge was already counted once in EDGE_A.
                    if (edge_ok && (src != dst))
                        for (int c = 0; c < WEIGHT_COLS; c++)
                            adj[src][c] <= acc_add(adj[src][c], fm_wm_row_in[c]);
                    edge_cnt <= edge_last ? '0 : edge_cnt + 1'b1;
                end
                ARGMAX: begin
                    y[row_cnt] <= best_idx;
                    row_cnt    <= row_last ? '0 : row_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_combination_block.sv
module tb_combination_block;

    localparam int FR = 6;
    localparam int WC = 3;
    localparam int NE = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] fm_wm_row_in [0:WC-1];
    logic [2:0]  coo_in [0:1];
    logic [2:0]  read_row;
    logic [2:0]  coo_address;
    logic        enable_read;
    logic        done_comb;
    logic [1:0]  y [0:FR-1];

    combination_block dut (
        .clk(clk), .reset(reset), .start(start),
        .fm_wm_row_in(fm_wm_row_in), .coo_in(coo_in),
        .read_row(read_row), .coo_address(coo_address),
        .enable_read(enable_read), .done_comb(done_comb), .y(y)
    );

    always #5 clk = ~clk;

    // Memories feeding the DUT (FM_WM rows and COO list), read combinationally.
    logic [15:0] fm  [0:FR-1][0:WC-1];
    logic [2:0]  coo [0:NE-1][0:1];

    always_comb begin
        for (int c = 0; c < WC; c++)
            fm_wm_row_in[c] = (read_row < 3'd6) ? fm[read_row][c] : 16'h0;
        coo_in[0] = (coo_address < 3'd6) ? coo[coo_address][0] : 3'd0;
        coo_in[1] = (coo_address < 3'd6) ? coo[coo_address][1] : 3'd0;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference: total sums per node from the graph, then overflow rule, then argmax.
    int ym [0:FR-1];

    function automatic void model_y();
        longint a [0:FR-1][0:WC-1];
        int s, d, best;
        for (int n = 0; n < FR; n++)
            for (int c = 0; c < WC; c++) a[n][c] = longint'(fm[n][c]);
        for (int e = 0; e < NE; e++) begin
            s = int'(coo[e][0]);
            d = int'(coo[e][1]);
            if (s < FR && d < FR)
                for (int c = 0; c < WC; c++) begin
                    a[d][c] += longint'(fm[s][c]);
                    if (s != d) a[s][c] += longint'(fm[d][c]);
                end
        end
        for (int n = 0; n < FR; n++) begin
            for (int c = 0; c < WC; c++) begin
`ifdef COMB_SATURATE_EN
                if (a[n][c] > 65535) a[n][c] = 65535;
`else
                a[n][c] = a[n][c] % 65536;
`endif
            end
            best = 0;
            for (int c = 1; c < WC; c++) if (a[n][c] > a[n][best]) best = c;
            ym[n] = best;
        end
    endfunction

    // Compare process: timeline of an operation measured from the start cycle.
    int  y_exp [0:FR-1];
    bit  busy = 0;
    bit  was_busy;
    int  start_cyc;
    int  dd, ee;
    int  exp_en, exp_rr, exp_ca, exp_done;

    always @(negedge clk) begin
        if (reset) begin
            busy = 0;
            for (int n = 0; n < FR; n++) y_exp[n] = 0;
            chk("rst_enable_read", enable_read, 0);
            chk("rst_done_comb", done_comb, 0);
            chk("rst_read_row", read_row, 0);
            chk("rst_coo_address", coo_address, 0);
            for (int n = 0; n < FR; n++) chk("rst_y", y[n], 0);
        end else begin
            was_busy = busy;
            exp_en = 0; exp_rr = 0; exp_ca = 0; exp_done = 0;
            dd = cyc - start_cyc;
            if (busy) begin
                if (dd >= 1 && dd <= FR) begin
                    exp_en = 1;
                    exp_rr = dd - 1;
                end else if (dd > FR && dd <= FR + 2 * NE) begin
                    ee = (dd - FR - 1) / 2;
                    exp_en = 1;
                    exp_ca = ee;
                    exp_rr = ((dd - FR - 1) % 2 == 0) ? int'(coo[ee][0]) : int'(coo[ee][1]);
                end else if (dd == 2 * FR + 2 * NE + 1) begin
                    exp_done = 1;
                end
            end
            chk("enable_read", enable_read, exp_en);
            chk("read_row", read_row, exp_rr);
            chk("coo_address", coo_address, exp_ca);
            chk("done_comb", done_comb, exp_done);
            if (busy && exp_done == 1) begin
                for (int n = 0; n < FR; n++) y_exp[n] = ym[n];
                busy = 0;
            end
            if (!busy)
                for (int n = 0; n < FR; n++) chk("y_hold", y[n], y_exp[n]);
            if (!was_busy && start) begin
                busy = 1;
                start_cyc = cyc;
                model_y();
            end
        end
    end

    // Launch one operation; optionally re-pulse start restart_at cycles later.
    task automatic run_op(input int restart_at);
        bit got;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (restart_at > 0) begin
            repeat (restart_at - 1) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done_comb) got = 1;
        end
        chk("done_seen", got, 1);
    endtask

    task automatic clear_mem();
        for (int n = 0; n < FR; n++)
            for (int c = 0; c < WC; c++) fm[n][c] = 16'h0;
        for (int e = 0; e < NE; e++) begin
            coo[e][0] = 3'd7;
            coo[e][1] = 3'd7;
        end
    endtask

    task automatic rand_rows();
        for (int n = 0; n < FR; n++)
            for (int c = 0; c < WC; c++)
                fm[n][c] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 3));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        clear_mem();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_done", done_comb, 0);

        // All edges out of range: only self loops.
        rand_rows();
        fm[0][0] = 16'd5; fm[0][1] = 16'd1; fm[0][2] = 16'd1;
        for (int e = 0; e < NE; e++) begin coo[e][0] = 3'd7; coo[e][1] = $urandom_range(0, 7); end
        run_op(0);
        chk("oor_y0", y[0], 0);

        // Single edge (0,1).
        clear_mem();
        fm[0][0] = 16'd5;
        fm[1][1] = 16'd9;
        coo[0][0] = 3'd0; coo[0][1] = 3'd1;
        run_op(0);
        chk("edge01_y0", y[0], 1);
        chk("edge01_y1", y[1], 1);

        // Self edge (2,2) and a tie on row 3.
        clear_mem();
        fm[2][0] = 16'd4; fm[2][1] = 16'd1; fm[2][2] = 16'd3;
        fm[3][0] = 16'd4; fm[3][1] = 16'd4;
        coo[3][0] = 3'd2; coo[3][1] = 3'd2;
        run_op(0);
        chk("self_y2", y[2], 0);
        chk("tie_y3", y[3], 0);

        // Overflow on element 0 of node 0.
        clear_mem();
        fm[0][0] = 16'hFFFF;
        fm[1][0] = 16'd2; fm[1][1] = 16'd3;
        coo[1][0] = 3'd0; coo[1][1] = 3'd1;
        run_op(0);
`ifdef COMB_SATURATE_EN
        chk("ovf_y0", y[0], 0);
`else
        chk("ovf_y0", y[0], 1);
`endif

        // Reset during EDGE_A of edge 2, then recompute.
        rand_rows();
        for (int e = 0; e < NE; e++) begin coo[e][0] = $urandom_range(0, 5); coo[e][1] = $urandom_range(0, 5); end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2 * FR - 2) @(posedge clk);
        #1 chk("abort_at_edge2", coo_address, 2);
        chk("abort_enable", enable_read, 1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (30) @(negedge clk);
        for (int n = 0; n < FR; n++) chk("abort_y_zero", y[n], 0);
        run_op(0);

        // start re-pulsed during ARGMAX must be ignored.
        rand_rows();
        run_op(2 * FR + 2 * NE - 5);
        repeat (30) @(negedge clk);

        // Randomized operations.
        for (int t = 0; t < 20; t++) begin
            rand_rows();
            for (int e = 0; e < NE; e++) begin
                coo[e][0] = $urandom_range(0, 7);
                coo[e][1] = ($urandom_range(0, 3) == 0) ? coo[e][0] : 3'($urandom_range(0, 7));
            end
            run_op(0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/combination_block.md
COMBINATION_BLOCK -- requirements
Module: combination_block

Interface
REQ-001 Parameter FEATURE_ROWS, 6, number of graph nodes (rows of the FM_WM product).
REQ-002 Parameter WEIGHT_COLS, 3, classes per node (columns of the FM_WM product).
REQ-003 Parameter DOT_PROD_WIDTH, 16, unsigned element width of FM_WM and of the accumulators.
REQ-004 Parameter NUM_EDGES, 6, COO edge-list length.
REQ-005 Parameter COO_BW, 3, node-index width in the COO list.
REQ-006 Parameter MAX_ADDRESS_WIDTH, 2, width of each argmax result.
REQ-007 Port clk, input, 1, single clock; all state SHALL change on its rising edge.
REQ-008 Port reset, input, 1, asynchronous active-high reset.
REQ-009 Port start, input, 1, single-cycle launch, driven by the transformation stage's done_trans.
REQ-010 Port fm_wm_row_in, input, DOT_PROD_WIDTH x [0:WEIGHT_COLS-1], FM_WM row selected by read_row, valid in the same cycle.
REQ-011 Port coo_in, input, COO_BW x [0:1], edge at coo_address: [0]=source, [1]=destination, valid in the same cycle.
REQ-012 Port read_row, output, clog2(FEATURE_ROWS), FM_WM row select.
REQ-013 Port coo_address, output, clog2(NUM_EDGES), edge index.
REQ-014 Port enable_read, output, 1, high while FM_WM or COO data is consumed.
REQ-015 Port done_comb, output, 1, one-cycle completion pulse.
REQ-016 Port y, output, MAX_ADDRESS_WIDTH x [0:FEATURE_ROWS-1], per-node argmax class.

Function
REQ-017 FSM states SHALL be IDLE, INIT, EDGE_A, EDGE_B, ARGMAX, DONE.
REQ-018 IDLE->INIT when start=1; start SHALL be ignored in every other state.
REQ-019 INIT SHALL last FEATURE_ROWS cycles; cycle n: read_row=n, adj[n] <= fm_wm_row_in (self loop).
REQ-020 Per edge e (0..NUM_EDGES-1), EDGE_A: coo_address=e, read_row=src, adj[dst] += row; EDGE_B: coo_address=e, read_row=dst, adj[src] += row.
REQ-021 Edge with src==dst SHALL update in EDGE_A only; EDGE_B performs no write.
REQ-022 Edge with src or dst >= FEATURE_ROWS SHALL cause no accumulator write in either cycle; both cycles still elapse.
REQ-023 Accumulation SHALL be element-wise unsigned, DOT_PROD_WIDTH bits, wrapping modulo 2^DOT_PROD_WIDTH (see REQ-032).
REQ-024 ARGMAX SHALL last FEATURE_ROWS cycles; cycle n writes y[n] = index of the largest adj[n] element; ties resolve to the lowest index.
REQ-025 DONE SHALL last one cycle with done_comb=1, then return to IDLE.
REQ-026 Latency: start sampled at edge k -> done_comb high in cycle k + FEATURE_ROWS + 2*NUM_EDGES + FEATURE_ROWS + 1 (k+25 at defaults).
REQ-027 enable_read SHALL be 1 exactly in INIT, EDGE_A and EDGE_B; read_row and coo_address SHALL be 0 outside those states.
REQ-028 y SHALL hold its values from DONE until the next ARGMAX overwrites them.

Reset
REQ-029 reset=1 SHALL immediately force IDLE; done_comb=0, enable_read=0, read_row=0, coo_address=0, y all 0, adj all 0, counters 0.
REQ-030 Reset asserted mid-operation SHALL abort with no done_comb; the next start SHALL recompute from scratch.

Configuration
REQ-031 Macro COMB_SATURATE_EN selects accumulator overflow behaviour.
REQ-032 Defined: each accumulator element saturates at 2^DOT_PROD_WIDTH-1; undefined: wraps modulo 2^DOT_PROD_WIDTH.

Verification
REQ-033 All edges src=7 (out of range); row0={5,1,1} -> adj0={5,1,1}, y[0]=0, done_comb in cycle k+25.
REQ-034 Edge (0,1), row0={5,0,0}, row1={0,9,0}, other edges out of range -> adj0=adj1={5,9,0}, y[0]=y[1]=1.
REQ-035 Self edge (2,2), row2={4,1,3} -> adj2={8,2,6}, y[2]=0; tie row3={4,4,0} -> y[3]=0.
REQ-036 Edge (0,1), row0={0xFFFF,0,0}, row1={2,3,0}: macro undefined -> adj0={0x0001,3,0}, y[0]=1; defined -> adj0={0xFFFF,3,0}, y[0]=0.
REQ-037 Reset pulsed during EDGE_A of edge 2 -> y all 0, no done_comb; new start -> correct result at k+25.
REQ-038 start re-pulsed during ARGMAX -> ignored; exactly one done_comb, at k+25 of the first start.
